// File: rtl/hs_da_pkg.sv
// Shared types and constants for the dual-channel DAC transmitter.
// Defines the FSM state encoding, the idle code and the occupancy-width helper.
package hs_da_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } state_t;

   localparam logic [9:0] DEF_MID = 10'd512;

   // Occupancy counter must represent 0..depth inclusive.
   function automatic int lvl_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/hs_dual_da_fifo.sv
// Show-ahead synchronous FIFO holding packed sample pairs.
// Flush empties it in one cycle and takes priority over push/pop.
module sync_fifo
   import hs_da_pkg::*;
#(
   parameter int WIDTH = 20,
   parameter int DEPTH = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      push,
   input  logic                      pop,
   input  logic                      flush,
   input  logic [WIDTH-1:0]          wr_data,
   output logic [WIDTH-1:0]          rd_data,
   output logic                      full,
   output logic                      empty,
   output logic [lvl_w(DEPTH)-1:0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = lvl_w(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic             w_push;
   logic             w_pop;

   assign full    = (r_level == LW'(DEPTH));
   assign empty   = (r_level == '0);
   assign level   = r_level;
   assign rd_data = r_mem[r_rd_ptr];
   assign w_push  = push && !full;
   assign w_pop   = pop && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_level <= r_level + LW'(w_push) - LW'(w_pop);
      end
   end

   // Storage carries no reset; a write during flush lands in a slot that is then invalid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/hs_dual_da.sv
// Dual-channel DAC transmitter: stream in, FIFO, fixed-rate parallel output
// with self-generated DAC sample clocks, idle mid-scale and sticky underrun.
module hs_dual_da
   import hs_da_pkg::*;
#(
   parameter int            DW    = 10,
   parameter int            DEPTH = 16,
   parameter int            DIV   = 2,
   parameter logic [DW-1:0] MID   = DW'(DEF_MID)
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst_n,
   input  logic                    en,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [DW-1:0]           s_data0,
   input  logic [DW-1:0]           s_data1,
   output logic [DW-1:0]           da0_data,
   output logic                    da0_clk,
   output logic [DW-1:0]           da1_data,
   output logic                    da1_clk,
   output logic [lvl_w(DEPTH)-1:0] level,
   output logic                    underrun,
   input  logic                    underrun_clr
);

   localparam int CW = $clog2(DIV);
   localparam int LW = lvl_w(DEPTH);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic            w_strobe;
   logic            r_da_clk;
   logic [DW-1:0]   r_da0;
   logic [DW-1:0]   r_da1;
   logic            r_underrun;
   logic            w_flush;
   logic            w_pop;
   logic            w_load;
   logic            w_urun_set;
   logic            w_full;
   logic            w_empty;
   logic [2*DW-1:0] w_rd_data;
   logic [LW-1:0]   w_level;

   sync_fifo #(
      .WIDTH (2*DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (sys_clk),
      .rst_n   (sys_rst_n),
      .push    (s_valid && s_ready),
      .pop     (w_pop),
      .flush   (w_flush),
      .wr_data ({s_data1, s_data0}),
      .rd_data (w_rd_data),
      .full    (w_full),
      .empty   (w_empty),
      .level   (w_level)
   );

   assign s_ready   = !w_full;
   assign level     = w_level;
   assign w_strobe  = (r_cnt == CW'(DIV-1));
   assign w_cnt_nxt = w_strobe ? '0 : r_cnt + 1'b1;

   always_comb begin
      w_state_nxt = r_state;
      w_flush     = 1'b0;
      w_pop       = 1'b0;
      w_load      = 1'b0;
      w_urun_set  = 1'b0;
      case (r_state)
         IDLE: begin
            w_flush = 1'b1;
            if (en) w_state_nxt = PRIME;
         end
         PRIME: begin
            if (w_level >= LW'(DEPTH/2)) w_state_nxt = RUN;
         end
         RUN: begin
            if (w_strobe) begin
               if (!w_empty) begin
                  w_pop  = 1'b1;
                  w_load = 1'b1;
               end else begin
                  w_urun_set  = 1'b1;
                  w_state_nxt = PRIME;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      // Disable overrides everything, including a pending pop or underrun.
      if (!en) begin
         w_state_nxt = IDLE;
         w_pop       = 1'b0;
         w_load      = 1'b0;
         w_urun_set  = 1'b0;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_da_clk   <= 1'b0;
         r_da0      <= MID;
         r_da1      <= MID;
         r_underrun <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         // Registered against the next count so the pin tracks cnt in the same cycle.
         r_da_clk <= (w_cnt_nxt >= CW'(DIV/2));
         if (!en) begin
            r_da0 <= MID;
            r_da1 <= MID;
         end else if (w_load) begin
            r_da0 <= w_rd_data[DW-1:0];
            r_da1 <= w_rd_data[2*DW-1:DW];
         end
         if (w_urun_set)        r_underrun <= 1'b1;
         else if (underrun_clr) r_underrun <= 1'b0;
      end
   end

   assign da0_data = r_da0;
   assign da1_data = r_da1;
   assign da0_clk  = r_da_clk;
   assign da1_clk  = r_da_clk;
   assign underrun = r_underrun;

endmodule

// File: tb/tb_hs_dual_da.sv
// Directed bench for hs_dual_da: DIV=2 instance for the data path and a
// DIV=4 instance for asynchronous reset and divider restart.
module tb_hs_dual_da;
   import hs_da_pkg::*;

   typedef struct {
      logic [9:0] d0;
      logic [9:0] d1;
      logic [9:0] e0;
      logic [9:0] e1;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, en, s_valid, clr;
   logic [9:0] s0, s1;
   logic [9:0] da0, da1;
   logic       dck0, dck1, s_ready, urun;
   logic [4:0] level;

   logic       rst_b, en_b, sv_b, clr_b;
   logic [9:0] s0_b, s1_b;
   logic [9:0] da0_b, da1_b;
   logic       dck0_b, dck1_b, s_ready_b, urun_b;
   logic [4:0] level_b;

   hs_dual_da #(.DW(10), .DEPTH(16), .DIV(2), .MID(10'd512)) u_dut (
      .sys_clk(clk), .sys_rst_n(rst_n), .en(en), .s_valid(s_valid), .s_ready(s_ready),
      .s_data0(s0), .s_data1(s1), .da0_data(da0), .da0_clk(dck0), .da1_data(da1),
      .da1_clk(dck1), .level(level), .underrun(urun), .underrun_clr(clr)
   );

   hs_dual_da #(.DW(10), .DEPTH(16), .DIV(4), .MID(10'd512)) u_dut4 (
      .sys_clk(clk), .sys_rst_n(rst_b), .en(en_b), .s_valid(sv_b), .s_ready(s_ready_b),
      .s_data0(s0_b), .s_data1(s1_b), .da0_data(da0_b), .da0_clk(dck0_b), .da1_data(da1_b),
      .da1_clk(dck1_b), .level(level_b), .underrun(urun_b), .underrun_clr(clr_b)
   );

   int          n_chk = 0;
   int          n_pass = 0;
   int          bad_chg = 0;
   logic        mon_on = 1'b0;
   logic        strm_on = 1'b0;
   logic [9:0]  p0, p1;
   logic        pck = 1'b0;
   logic        rose = 1'b0;
   logic [19:0] last_cap;
   logic [19:0] q[$];
   vec_t        vt[8];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: actual %0d required %0d", nm, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (mon_on && (da0 != p0 || da1 != p1) && !(pck && !dck0)) bad_chg++;
      if (mon_on && (dck0 != dck1)) bad_chg++;
      rose = !pck && dck0;
      pck  = dck0;
      p0   = da0;
      p1   = da1;
      if (strm_on && rose && ({da0, da1} != last_cap)) begin
         last_cap = {da0, da1};
         if (q.size() == 0) chk("stream_underflow", q.size(), 1);
         else chk("stream", int'({da0, da1}), int'(q.pop_front()));
      end
   endtask

   task automatic push_pair(input logic [9:0] a, input logic [9:0] b);
      s_valid = 1'b1;
      s0 = a;
      s1 = b;
      step();
      s_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: actual running required finished");
      $fatal(1);
   end

   initial begin
      int w;
      int k;
      logic acc;
      int exp_b[4];

      rst_n = 1'b0; en = 1'b0; s_valid = 1'b0; clr = 1'b0; s0 = '0; s1 = '0;
      rst_b = 1'b0; en_b = 1'b0; sv_b = 1'b0; clr_b = 1'b0; s0_b = '0; s1_b = '0;
      for (int i = 0; i < 8; i++) begin
         vt[i].d0 = 10'(i);
         vt[i].d1 = 10'(1023 - i);
         vt[i].e0 = 10'(i);
         vt[i].e1 = 10'(1023 - i);
      end

      #12;
      chk("rst_da0", da0, 512);
      chk("rst_da1", da1, 512);
      chk("rst_clk", dck0, 0);
      chk("rst_level", level, 0);
      chk("rst_ready", s_ready, 1);
      chk("rst_urun", urun, 0);

      @(posedge clk);
      #1;
      rst_n = 1'b1;
      p0 = da0; p1 = da1; pck = dck0;
      for (int t = 1; t <= 4; t++) begin
         step();
         chk($sformatf("idle_clk_t%0d", t), dck0, t % 2);
      end
      chk("idle_da0", da0, 512);
      chk("idle_da1", da1, 512);

      // Enable one cycle ahead so the first push is not flushed by IDLE.
      en = 1'b1;
      step();
      for (int i = 0; i < 8; i++) push_pair(vt[i].d0, vt[i].d1);
      chk("prime_level", level, 8);
      chk("prime_ready", s_ready, 1);

      mon_on = 1'b1;
      w = 0;
      while (da0 == 512 && w < 20) begin step(); w++; end
      chk("run_start", int'(da0 != 512), 1);
      for (int i = 0; i < 8; i++) begin
         w = 0;
         do begin step(); w++; end while (!rose && w < 8);
         chk("rise_wait", rose, 1);
         chk($sformatf("da0_s%0d", i), da0, vt[i].e0);
         chk($sformatf("da1_s%0d", i), da1, vt[i].e1);
      end

      // The cycle after the last capture is the empty strobe; clear collides with set.
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("urun_set_wins", urun, 1);
      chk("hold_da0", da0, 7);
      chk("hold_da1", da1, 1016);

      push_pair(10'd55, 10'd66);
      repeat (4) step();
      chk("prime_nopop_level", level, 1);
      chk("prime_nopop_da0", da0, 7);

      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("urun_clr", urun, 0);

      q.push_back({10'd55, 10'd66});
      last_cap = {da0, da1};
      strm_on = 1'b1;
      k = 0;
      w = 0;
      s_valid = 1'b1;
      while (level != 16 && w < 60) begin
         s0 = 10'(100 + k);
         s1 = 10'(900 - k);
         acc = s_ready;
         step();
         if (acc) begin q.push_back({s0, s1}); k++; end
         w++;
      end
      chk("full_level", level, 16);
      chk("full_ready", s_ready, 0);
      s0 = 10'd1000;
      s1 = 10'd1000;
      step();
      s_valid = 1'b0;
      w = 0;
      while (!urun && w < 100) begin step(); w++; end
      chk("drain_urun", urun, 1);
      chk("drain_q_empty", q.size(), 0);
      strm_on = 1'b0;
      chk("chg_on_fall", bad_chg, 0);
      mon_on = 1'b0;

      for (int i = 0; i < 8; i++) push_pair(10'(200 + i), 10'(300 + i));
      w = 0;
      while (level != 5 && w < 40) begin step(); w++; end
      chk("lvl5_reached", level, 5);
      en = 1'b0;
      step();
      chk("dis_da0", da0, 512);
      chk("dis_da1", da1, 512);
      step();
      chk("idle_flush", level, 0);
      push_pair(10'd1, 10'd2);
      chk("idle_discard", level, 0);
      en = 1'b1;
      step();
      for (int i = 0; i < 3; i++) push_pair(10'(400 + i), 10'(500 + i));
      repeat (6) step();
      chk("reprime_level", level, 3);
      chk("reprime_da0", da0, 512);

      chk("b_rst_da0", da0_b, 512);
      chk("b_rst_level", level_b, 0);
      rst_b = 1'b1;
      en_b = 1'b1;
      step();
      for (int i = 0; i < 8; i++) begin
         sv_b = 1'b1;
         s0_b = 10'(600 + i);
         s1_b = 10'(700 + i);
         step();
      end
      sv_b = 1'b0;
      w = 0;
      while (da0_b == 512 && w < 60) begin step(); w++; end
      chk("b_run", da0_b, 600);
      w = 0;
      while (!dck0_b && w < 8) begin step(); w++; end
      chk("b_clk_high", dck0_b, 1);
      #3;
      rst_b = 1'b0;
      #1;
      chk("b_arst_da0", da0_b, 512);
      chk("b_arst_da1", da1_b, 512);
      chk("b_arst_clk0", dck0_b, 0);
      chk("b_arst_clk1", dck1_b, 0);
      chk("b_arst_level", level_b, 0);
      chk("b_arst_ready", s_ready_b, 1);
      chk("b_arst_urun", urun_b, 0);
      en_b = 1'b0;
      @(posedge clk);
      #1;
      rst_b = 1'b1;
      exp_b[0] = 0; exp_b[1] = 1; exp_b[2] = 1; exp_b[3] = 0;
      for (int t = 0; t < 4; t++) begin
         step();
         chk($sformatf("b_clk_t%0d", t + 1), dck0_b, exp_b[t]);
      end
      chk("b_post_da0", da0_b, 512);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/hs_dual_da.md
# hs_dual_da

Dual-channel high-speed DAC transmitter: the output-side counterpart of the dual ADC capture path on the same board. It accepts paired 10-bit samples through a valid/ready stream, buffers them in a small FIFO and drives two parallel DACs at a fixed sample rate of sys_clk/DIV. It generates the DAC sample clocks itself, holds mid-scale when idle and flags underruns.

## Interface
- DW, 10: sample width per channel
- DEPTH, 16: FIFO depth in sample pairs; power of 2, ≥4
- DIV, 2: sys_clk cycles per DAC sample; even, ≥2
- MID, 10'd512: idle/reset output code
- sys_clk  in  1  system clock, all logic on rising edge
- sys_rst_n  in  1  asynchronous, active-low reset
- en  in  1  transmit enable (level)
- s_valid  in  1  input sample pair valid
- s_ready  out  1  FIFO can accept; = not full
- s_data0  in  DW  channel 0 sample
- s_data1  in  DW  channel 1 sample
- da0_data  out  DW  DAC 0 parallel data, registered
- da0_clk  out  1  DAC 0 sample clock, registered
- da1_data  out  DW  DAC 1 parallel data, registered
- da1_clk  out  1  DAC 1 sample clock, identical to da0_clk
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- underrun  out  1  sticky underrun flag
- underrun_clr  in  1  clears underrun (one-cycle pulse)

## Operation
- Push on s_valid && s_ready. s_ready = (level != DEPTH). A push while full is impossible. Push and pop in the same cycle leave level unchanged.
- Divider counter cnt runs 0..DIV-1 continuously out of reset, in every state. The strobe is cnt == DIV-1.
- FSM states:
  - IDLE: outputs MID, FIFO flushed each cycle, pushes accepted but discarded. On en=1, go to PRIME.
  - PRIME: fill the FIFO with no pops; outputs keep their last value. On level ≥ DEPTH/2, go to RUN.
  - RUN: at each strobe, pop one pair into da0/da1_data. Strobe with FIFO empty: no pop, data held, underrun set, go to PRIME.
- en=0 in any state: go to IDLE the next cycle, and da*_data take MID at that same edge.
- underrun_clr and a new underrun in the same cycle: the set wins.

## Timing
- Reset values:
  - da0_data, da1_data = MID; da0_clk, da1_clk = 0.
  - level = 0, s_ready = 1, underrun = 0, cnt = 0, state IDLE.
- da*_data change only on the edge where cnt wraps DIV-1→0, except the en=0 forced MID.
- da*_clk = 1 while cnt ∈ [DIV/2, DIV-1], registered. The rising edge comes DIV/2 cycles after each data update, which gives the DACs half a sample period of setup and hold. The DACs latch on the rising edge.
- Pop-to-pin latency: 1 cycle, since the data register loads at the strobe edge. First sample after PRIME→RUN appears at the first strobe after the transition.
- level updates one cycle after a push/pop. s_ready deasserts in the cycle after the push that fills the FIFO.
- Reset mid-operation: every register returns to its reset value immediately. There is no partial-sample glitch beyond the asynchronous clear.

## Structure
- Package hs_da_pkg:
  - typedef state_t {IDLE, PRIME, RUN}
  - default MID constant
  - helper for the level width
- Sub-module sync_fifo:
  - parameters WIDTH=2*DW, DEPTH
  - ports: push, pop, flush, full, empty, level, wr/rd data
  - show-ahead read
- Top level holds the FSM, divider, output registers and underrun flag.

## Test plan
- Reset, en=0 → da*_data=512, da*_clk toggles with period DIV, s_ready=1, level=0.
- en=1, push 8 pairs (ramp 0..7 / 1023..1016), DEPTH=16, DIV=2 → RUN after level=8. da0 sequence 0,1,…,7 and da1 1023,…,1016, each changing on da_clk falling and stable at da_clk rising.
- Stop pushing in RUN → after the last sample, data holds 7/1016, underrun=1, state PRIME. underrun_clr pulse → underrun=0.
- Push continuously with no pops (PRIME, en held but source faster) until full → level=16, s_ready=0 the next cycle, no overwrite of stored data.
- Drop en mid-RUN with level=5 → da*_data=512 at the next edge, level=0, state IDLE. Re-enable → PRIME again.
- Assert sys_rst_n=0 mid-sample with DIV=4 → all outputs at reset values asynchronously. After release, cnt restarts at 0 and da_clk is first high at cnt=2.
